pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Owns the program counter and instruction-fetch handshake for the pipelined CPU (IF stage).
//  Drives o_pc into the external PC-increment adder (second operand tied to 32'd4) and consumes its sum on i_pc_plus4.
//  Selects next PC from sequential / jump (ID) / branch (EX); fills the IF/ID register; absorbs stalls with a 1-entry skid.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC after reset
//  EXC_VECTOR  32'h0000_0180  target on misaligned redirect (PC_ALIGN_CHECK_EN only)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   synchronous, active-high
//  o_pc          out  32  current fetch address; drives adder operand 1 and imem address
//  i_pc_plus4    in   32  adder sum = o_pc + 4 (combinational, same cycle)
//  o_imem_req    out  1   fetch request; o_pc held stable while req=1 and ack=0
//  i_imem_ack    in   1   request done; i_imem_rdata valid this cycle (may be same cycle as req)
//  i_imem_rdata  in   32  fetched instruction
//  i_stall       in   1   hazard unit: hold IF/ID register
//  i_jmp         in   1   jump from ID;  i_jmp_target in 32
//  i_br_taken    in   1   taken branch from EX;  i_br_target in 32
//  o_if_valid    out  1   IF/ID register holds a valid instruction
//  o_if_instr    out  32  IF/ID instruction;  o_if_pc out 32 its PC;  o_if_pc4 out 32 its PC+4
//  o_flush       out  1   one-cycle pulse: redirect taken, younger stages must squash
//  o_misalign    out  1   one-cycle pulse on misaligned redirect (PC_ALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Reset: o_pc=RESET_PC, state S_IDLE, o_imem_req=0, o_if_valid=0, o_if_instr/pc/pc4=0, o_flush=0, o_misalign=0, skid empty, drop=0.
//  States: S_IDLE -> S_REQ unconditionally next cycle. S_REQ: o_imem_req=1. S_HOLD: req=0, skid full, waiting for !i_stall.
//  Redirect priority: reset > i_br_taken > i_jmp > i_stall > sequential. Redirect = br or jmp.
//  S_REQ ack, no redirect, drop=0: if IF/ID empty or !i_stall -> IF/ID <= {rdata, o_pc, i_pc_plus4}, valid=1, o_pc <= i_pc_plus4, stay S_REQ;
//    else (IF/ID valid and i_stall) -> skid <= {rdata, o_pc, i_pc_plus4}, o_pc <= i_pc_plus4, go S_HOLD.
//  S_REQ no ack: o_pc unchanged; IF/ID valid cleared if consumed (!i_stall) else held.
//  S_HOLD: when !i_stall -> skid moves to IF/ID, skid empties, go S_REQ (req reasserted next cycle).
//  Throughput: 1 instr/cycle with same-cycle ack; first IF/ID valid 2 cycles after reset release.
//  Redirect (any state): o_flush=1 next cycle; o_if_valid<=0; skid emptied; o_misalign per option.
//   - S_IDLE/S_HOLD, or S_REQ with ack same cycle: data discarded, o_pc <= target, go/stay S_REQ.
//   - S_REQ without ack: o_pc held (address stable rule); drop<=1, redir_pc<=target; later redirect overwrites redir_pc.
//   - ack while drop=1: data discarded, o_pc <= redir_pc, drop<=0, req stays asserted.
//  Redirect overrides i_stall the same cycle (flush wins). Reset mid-request: outstanding ack ignored (state S_IDLE).
//  Arithmetic: no internal adder; PC+4 only from i_pc_plus4, wraps 32'hFFFF_FFFC -> 32'h0 (carry-out ignored).
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: redirect target with [1:0]!=0 -> o_pc/redir_pc use EXC_VECTOR, o_misalign pulses with o_flush.
//  Undefined: target used as given (bits [1:0] passed through), o_misalign tied 0.
// STRUCTURE
//  Shared header fetch_defs.vh: state encodings S_IDLE/S_REQ/S_HOLD, IF/ID bundle width (96), NOP encoding 32'h0.
//  One sub-module: fetch_skid_buf (1-entry 96-bit buffer: load/unload/clear, o_full).
//  Next-PC mux and FSM live in top; adder stays external.
// TESTING
//  1 reset release, ack tied 1 -> o_pc 0,4,8,C on consecutive cycles; o_if_valid first high cycle 2, o_if_pc=0, o_if_pc4=4.
//  2 i_stall high 3 cycles with IF/ID valid, ack 1 -> 1 instr to skid, S_HOLD, req=0; release -> skid to IF/ID, no instr lost/duped.
//  3 ack delayed 3 cycles, i_jmp target 32'h40 in cycle 1 -> o_pc held till ack, data dropped, next fetch at 32'h40, o_flush 1 cycle.
//  4 i_br_taken 32'h100 and i_jmp 32'h200 same cycle -> o_pc=32'h100 (branch wins).
//  5 reset asserted while req pending, ack arrives next cycle -> ignored; o_pc=RESET_PC, o_if_valid=0.
//  6 PC_ALIGN_CHECK_EN, i_jmp target 32'h42 -> o_pc=EXC_VECTOR, o_misalign=1; undefined -> o_pc=32'h42, o_misalign=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the IF stage: FSM states, IF/ID bundle layout and NOP encoding.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int IFID_W = 96;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID bundle, instr in the top word so the packed vector reads {instr, pc, pc4}
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_skid_buf.sv
// One-entry IF/ID skid buffer: catches the instruction fetched in the cycle a stall appears.
module pc_fetch_ctrl_skid_buf
  import pc_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [IFID_W-1:0] din,
  output logic [IFID_W-1:0] dout,
  output logic              full
);

  logic [IFID_W-1:0] data_reg;
  logic              full_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= din;
      full_reg <= 1'b1;
    end else if (unload) begin
      full_reg <= 1'b0;
    end
  end

  assign dout = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF stage: program counter, next-PC selection, imem handshake and IF/ID register.
// Optional build macro PC_ALIGN_CHECK_EN redirects misaligned targets to EXC_VECTOR.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] o_pc,
  input  logic [31:0] i_pc_plus4,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic        o_flush,
  output logic        o_misalign
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  redir_pc_reg, redir_pc_next;
  logic         drop_reg, drop_next;
  ifid_t        ifid_reg, ifid_next;
  logic         if_valid_reg, if_valid_next;
  logic         flush_reg, flush_next;
  logic         misalign_reg, misalign_next;

  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [IFID_W-1:0] skid_dout;
  ifid_t             fetched;

  logic        redirect;
  logic [31:0] raw_tgt;
  logic [31:0] eff_tgt;
  logic        tgt_misaligned;

  assign fetched  = {i_imem_rdata, pc_reg, i_pc_plus4};
  assign redirect = i_br_taken | i_jmp;
  assign raw_tgt  = i_br_taken ? i_br_target : i_jmp_target;

`ifdef PC_ALIGN_CHECK_EN
  assign tgt_misaligned = is_misaligned(raw_tgt);
`else
  assign tgt_misaligned = 1'b0;
`endif

  assign eff_tgt = tgt_misaligned ? EXC_VECTOR : raw_tgt;

  pc_fetch_ctrl_skid_buf u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (fetched),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      redir_pc_reg <= RESET_PC;
      drop_reg     <= 1'b0;
      ifid_reg     <= {NOP_INSTR, 32'h0, 32'h0};
      if_valid_reg <= 1'b0;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      redir_pc_reg <= redir_pc_next;
      drop_reg     <= drop_next;
      ifid_reg     <= ifid_next;
      if_valid_reg <= if_valid_next;
      flush_reg    <= flush_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    redir_pc_next = redir_pc_reg;
    drop_next     = drop_reg;
    ifid_next     = ifid_reg;
    if_valid_next = if_valid_reg;
    flush_next    = 1'b0;
    misalign_next = 1'b0;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    if (redirect) begin
      flush_next    = 1'b1;
      misalign_next = tgt_misaligned;
      if_valid_next = 1'b0;
      skid_clear    = 1'b1;
      if (state_reg == S_REQ && !i_imem_ack) begin
        // imem address must stay put until ack; remember where to go afterwards
        drop_next     = 1'b1;
        redir_pc_next = eff_tgt;
      end else begin
        drop_next  = 1'b0;
        pc_next    = eff_tgt;
        state_next = S_REQ;
      end
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_REQ;
        S_REQ: begin
          if (i_imem_ack) begin
            if (drop_reg) begin
              pc_next   = redir_pc_reg;
              drop_next = 1'b0;
              if (!i_stall) if_valid_next = 1'b0;
            end else if (!if_valid_reg || !i_stall) begin
              ifid_next     = fetched;
              if_valid_next = 1'b1;
              pc_next       = i_pc_plus4;
            end else begin
              skid_load  = 1'b1;
              pc_next    = i_pc_plus4;
              state_next = S_HOLD;
            end
          end else if (!i_stall) begin
            if_valid_next = 1'b0;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            ifid_next     = skid_dout;
            if_valid_next = skid_full;
            skid_unload   = 1'b1;
            state_next    = S_REQ;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign o_pc       = pc_reg;
  assign o_imem_req = (state_reg == S_REQ);
  assign o_if_valid = if_valid_reg;
  assign o_if_instr = ifid_reg.instr;
  assign o_if_pc    = ifid_reg.pc;
  assign o_if_pc4   = ifid_reg.pc4;
  assign o_flush    = flush_reg;
  assign o_misalign = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a scoreboard of fetched instructions.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] o_pc;
  logic [31:0] i_pc_plus4;
  logic        o_imem_req;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_jmp;
  logic [31:0] i_jmp_target;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic        o_flush;
  logic        o_misalign;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        drop_m   = 1'b0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_pc  = 32'h0;
  logic [31:0] exp_pc_mis;
  logic [31:0] exp_misalign;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .o_pc         (o_pc),
    .i_pc_plus4   (i_pc_plus4),
    .o_imem_req   (o_imem_req),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .i_stall      (i_stall),
    .i_jmp        (i_jmp),
    .i_jmp_target (i_jmp_target),
    .i_br_taken   (i_br_taken),
    .i_br_target  (i_br_target),
    .o_if_valid   (o_if_valid),
    .o_if_instr   (o_if_instr),
    .o_if_pc      (o_if_pc),
    .o_if_pc4     (o_if_pc4),
    .o_flush      (o_flush),
    .o_misalign   (o_misalign)
  );

  // external adder and a pattern memory keyed by address
  assign i_pc_plus4   = o_pc + 32'd4;
  assign i_imem_rdata = o_pc ^ 32'hC0DE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping on the settled pre-edge values, then advance to edge+1.
  task automatic tick();
    entry_t e;
    if (hold_chk) check("pc_hold", o_pc, hold_pc);
    hold_chk = !reset && o_imem_req && !i_imem_ack;
    hold_pc  = o_pc;
    if (reset) begin
      sb.delete();
      drop_m = 1'b0;
    end else if (i_br_taken || i_jmp) begin
      sb.delete();
      drop_m = o_imem_req && !i_imem_ack;
    end else begin
      if (o_if_valid && !i_stall) begin
        check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("if_instr", o_if_instr, e.instr);
          check("if_pc", o_if_pc, e.pc);
          check("if_pc4", o_if_pc4, e.pc4);
          $display("consume pc=%h instr=%h", o_if_pc, o_if_instr);
        end
      end
      if (o_imem_req && i_imem_ack) begin
        if (drop_m) drop_m = 1'b0;
        else sb.push_back({i_imem_rdata, o_pc, i_pc_plus4});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    i_imem_ack   = 1'b1;
    i_stall      = 1'b0;
    i_jmp        = 1'b0;
    i_jmp_target = 32'h0;
    i_br_taken   = 1'b0;
    i_br_target  = 32'h0;

    // reset state
    tick();
    tick();
    check("rst_pc", o_pc, 32'h0);
    check("rst_req", {31'b0, o_imem_req}, 32'd0);
    check("rst_valid", {31'b0, o_if_valid}, 32'd0);
    check("rst_instr", o_if_instr, 32'h0);
    check("rst_if_pc", o_if_pc, 32'h0);
    check("rst_if_pc4", o_if_pc4, 32'h0);
    check("rst_flush", {31'b0, o_flush}, 32'd0);
    check("rst_misalign", {31'b0, o_misalign}, 32'd0);

    // sequential fetch with same-cycle ack
    reset = 1'b0;
    tick();
    check("c1_req", {31'b0, o_imem_req}, 32'd1);
    check("c1_pc", o_pc, 32'h0);
    check("c1_valid", {31'b0, o_if_valid}, 32'd0);
    tick();
    check("c2_pc", o_pc, 32'h4);
    check("c2_valid", {31'b0, o_if_valid}, 32'd1);
    check("c2_if_pc", o_if_pc, 32'h0);
    check("c2_if_pc4", o_if_pc4, 32'h4);
    tick();
    check("c3_pc", o_pc, 32'h8);
    tick();
    check("c4_pc", o_pc, 32'hC);

    // stall for 3 cycles: one instruction into the skid, request drops
    i_stall = 1'b1;
    tick();
    check("stall1_req", {31'b0, o_imem_req}, 32'd0);
    tick();
    tick();
    check("stall3_req", {31'b0, o_imem_req}, 32'd0);
    check("stall3_pc", o_pc, 32'h10);
    check("stall3_if_pc", o_if_pc, 32'h8);
    i_stall = 1'b0;
    tick();
    check("unstall_req", {31'b0, o_imem_req}, 32'd1);
    check("unstall_valid", {31'b0, o_if_valid}, 32'd1);
    check("unstall_if_pc", o_if_pc, 32'hC);

    // jump while ack is delayed: address held, returned data dropped
    i_imem_ack   = 1'b0;
    i_jmp        = 1'b1;
    i_jmp_target = 32'h40;
    tick();
    i_jmp = 1'b0;
    check("jmp_flush", {31'b0, o_flush}, 32'd1);
    check("jmp_valid", {31'b0, o_if_valid}, 32'd0);
    check("jmp_pc_held", o_pc, 32'h10);
    tick();
    check("jmp_flush_end", {31'b0, o_flush}, 32'd0);
    tick();
    i_imem_ack = 1'b1;
    tick();
    check("drop_pc", o_pc, 32'h40);
    check("drop_valid", {31'b0, o_if_valid}, 32'd0);
    tick();
    check("jmp_fetch_valid", {31'b0, o_if_valid}, 32'd1);
    check("jmp_fetch_pc", o_if_pc, 32'h40);

    // branch beats a simultaneous jump
    i_br_taken   = 1'b1;
    i_br_target  = 32'h100;
    i_jmp        = 1'b1;
    i_jmp_target = 32'h200;
    tick();
    i_br_taken = 1'b0;
    i_jmp      = 1'b0;
    check("br_pc", o_pc, 32'h100);
    check("br_flush", {31'b0, o_flush}, 32'd1);
    tick();
    check("br_if_pc", o_if_pc, 32'h100);
    check("br_next_pc", o_pc, 32'h104);

    // PC wraps through the top of the address space
    i_br_taken  = 1'b1;
    i_br_target = 32'hFFFF_FFFC;
    tick();
    i_br_taken = 1'b0;
    check("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", o_pc, 32'h0);
    check("wrap_if_pc4", o_if_pc4, 32'h0);

    // reset while a request is outstanding; the late ack is ignored
    i_br_taken  = 1'b1;
    i_br_target = 32'h80;
    tick();
    i_br_taken = 1'b0;
    i_imem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    i_imem_ack = 1'b1;
    tick();
    check("rstmid_pc", o_pc, 32'h0);
    check("rstmid_valid", {31'b0, o_if_valid}, 32'd0);
    check("rstmid_req", {31'b0, o_imem_req}, 32'd1);
    tick();
    check("rstmid_if_pc", o_if_pc, 32'h0);

    // misaligned jump target
`ifdef PC_ALIGN_CHECK_EN
    exp_pc_mis   = 32'h0000_0180;
    exp_misalign = 32'd1;
`else
    exp_pc_mis   = 32'h0000_0042;
    exp_misalign = 32'd0;
`endif
    i_jmp        = 1'b1;
    i_jmp_target = 32'h42;
    tick();
    i_jmp = 1'b0;
    check("mis_pc", o_pc, exp_pc_mis);
    check("mis_flag", {31'b0, o_misalign}, exp_misalign);
    check("mis_flush", {31'b0, o_flush}, 32'd1);
    i_jmp        = 1'b1;
    i_jmp_target = 32'h10;
    tick();
    i_jmp = 1'b0;
    check("aligned_flag", {31'b0, o_misalign}, 32'd0);
    check("aligned_pc", o_pc, 32'h10);
    repeat (4) tick();
    check("tail_pc", o_pc, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
